// File: rtl/fft_sink_pkg.sv
// Shared definitions for the FFT result-stream sink blocks: default widths
// and the framing state encoding.
package fft_sink_pkg;

   localparam int DEFAULT_IW     = 16;
   localparam int DEFAULT_LGSIZE = 10;

   typedef enum logic {
      HUNT,
      ACCUM
   } frame_state_t;

endpackage

// File: rtl/fft_magsq.sv
// Three-stage re^2 + im^2 pipeline: operand register, squares, sum.
// Valid bit and bin index travel alongside the data unchanged.
module fft_magsq
   import fft_sink_pkg::*;
#(
   parameter int IW = DEFAULT_IW,
   parameter int BW = DEFAULT_LGSIZE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ce,
   input  logic [2*IW-1:0] i_result,
   input  logic [BW-1:0]   i_bin,
   output logic            o_valid,
   output logic [2*IW-1:0] o_mag,
   output logic [BW-1:0]   o_bin
);

   logic                   s1_valid;
   logic signed [IW-1:0]   s1_re;
   logic signed [IW-1:0]   s1_im;
   logic [BW-1:0]          s1_bin;

   logic                   s2_valid;
   logic [2*IW-1:0]        s2_sq_re;
   logic [2*IW-1:0]        s2_sq_im;
   logic [BW-1:0]          s2_bin;

   logic signed [2*IW-1:0] re_ext;
   logic signed [2*IW-1:0] im_ext;
   logic signed [2*IW-1:0] sq_re;
   logic signed [2*IW-1:0] sq_im;

   // Each square is at most 2^(2*IW-2), so the 2*IW-bit product is exact.
   assign re_ext = (2*IW)'(s1_re);
   assign im_ext = (2*IW)'(s1_im);
   assign sq_re  = re_ext * re_ext;
   assign sq_im  = im_ext * im_ext;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         o_valid  <= 1'b0;
      end else begin
         s1_valid <= i_ce;
         s2_valid <= s1_valid;
         o_valid  <= s2_valid;
      end
   end

   // NOTE: datapath registers carry no reset; every consumer qualifies them
   // with the matching valid bit, so their post-reset contents are never seen.
   always_ff @(posedge clk) begin
      s1_re    <= i_result[2*IW-1:IW];
      s1_im    <= i_result[IW-1:0];
      s1_bin   <= i_bin;
      s2_sq_re <= $unsigned(sq_re);
      s2_sq_im <= $unsigned(sq_im);
      s2_bin   <= s1_bin;
      o_mag    <= s2_sq_re + s2_sq_im;
      o_bin    <= s2_bin;
   end

endmodule

// File: rtl/fft_peak_detect.sv
// Natural-order FFT result sink: frames the stream, squares each bin and reports
// the largest bin per frame. Define FFT_PEAK_SKIP_DC_EN to exclude bin 0.
module fft_peak_detect
   import fft_sink_pkg::*;
#(
   parameter int IW     = DEFAULT_IW,
   parameter int LGSIZE = DEFAULT_LGSIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_ce,
   input  logic [2*IW-1:0]   i_result,
   input  logic              i_sync,
   output logic [LGSIZE-1:0] o_peak_bin,
   output logic [2*IW-1:0]   o_peak_mag,
   output logic              o_valid,
   output logic              o_frame_err
);

   localparam logic [LGSIZE-1:0] LAST_BIN = '1;
`ifdef FFT_PEAK_SKIP_DC_EN
   localparam logic [LGSIZE-1:0] FIRST_BIN = LGSIZE'(1);
`else
   localparam logic [LGSIZE-1:0] FIRST_BIN = '0;
`endif

   frame_state_t      state;
   logic [LGSIZE-1:0] cnt;

   logic              take;
   logic              err;
   logic [LGSIZE-1:0] take_bin;

   // A sync always starts a frame; otherwise only an open frame with bins
   // still outstanding accepts the sample. cnt == 0 in ACCUM means a frame
   // just completed and the next sample owes us a sync.
   assign take     = i_ce && (i_sync || (state == ACCUM && cnt != '0));
   assign err      = i_ce && state == ACCUM && (i_sync ? (cnt != '0) : (cnt == '0));
   assign take_bin = i_sync ? '0 : cnt;

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= HUNT;
         cnt         <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_frame_err <= err;
         if (take) begin
            state <= ACCUM;
            cnt   <= take_bin + LGSIZE'(1);
         end else if (err) begin
            state <= HUNT;
         end
      end
   end

   logic              m_valid;
   logic [2*IW-1:0]   m_mag;
   logic [LGSIZE-1:0] m_bin;

   fft_magsq #(
      .IW (IW),
      .BW (LGSIZE)
   ) u_magsq (
      .clk      (clk),
      .rst      (rst),
      .i_ce     (take),
      .i_result (i_result),
      .i_bin    (take_bin),
      .o_valid  (m_valid),
      .o_mag    (m_mag),
      .o_bin    (m_bin)
   );

   logic [LGSIZE-1:0] cand_bin;
   logic [2*IW-1:0]   cand_mag;
   logic [LGSIZE-1:0] next_bin;
   logic [2*IW-1:0]   next_mag;
   logic              frame_done;

   // An aborted frame never reaches LAST_BIN, and the new frame's first
   // eligible bin reloads the candidate, so aborted data cannot leak out.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      next_bin = cand_bin;
      next_mag = cand_mag;
      if (m_valid) begin
         if (m_bin == FIRST_BIN) begin
            next_bin = m_bin;
            next_mag = m_mag;
         end else if (m_bin > FIRST_BIN && m_mag > cand_mag) begin
            next_bin = m_bin;
            next_mag = m_mag;
         end
      end
   end

   assign frame_done = m_valid && m_bin == LAST_BIN;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cand_bin   <= '0;
         cand_mag   <= '0;
         o_peak_bin <= '0;
         o_peak_mag <= '0;
         o_valid    <= 1'b0;
      end else begin
         cand_bin <= next_bin;
         cand_mag <= next_mag;
         o_valid  <= frame_done;
         if (frame_done) begin
            o_peak_bin <= next_bin;
            o_peak_mag <= next_mag;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect (N=16): a frame-level model queues the
// expected reports and framing errors, a monitor checks them as they appear.
module tb_fft_peak_detect;

   localparam int IW     = 16;
   localparam int LGSIZE = 4;
   localparam int N      = 1 << LGSIZE;
`ifdef FFT_PEAK_SKIP_DC_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_ce = 1'b0;
   logic              i_sync = 1'b0;
   logic [2*IW-1:0]   i_result = '0;
   logic [LGSIZE-1:0] o_peak_bin;
   logic [2*IW-1:0]   o_peak_mag;
   logic              o_valid;
   logic              o_frame_err;

   always #5 clk = ~clk;

   fft_peak_detect #(
      .IW     (IW),
      .LGSIZE (LGSIZE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_ce        (i_ce),
      .i_result    (i_result),
      .i_sync      (i_sync),
      .o_peak_bin  (o_peak_bin),
      .o_peak_mag  (o_peak_mag),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err)
   );

   int     n_checks = 0;
   int     n_errors = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int     bin;
      longint mag;
      longint cyc;
   } rep_t;

   rep_t   exp_rep[$];
   longint exp_err[$];
   longint fr_mag[$];
   bit     m_hunt = 1'b1;

   function automatic longint mag_sq(input int re, input int im);
      return longint'(re) * re + longint'(im) * im;
   endfunction

   // edge_n: number of the clock edge that accepts this sample.
   task automatic model_accept(input int re, input int im, input bit sync, input longint edge_n);
      rep_t r;
      int   best;
      if (sync) begin
         if (!m_hunt && fr_mag.size() != 0) exp_err.push_back(edge_n);
         m_hunt = 1'b0;
         fr_mag.delete();
      end else if (m_hunt) begin
         return;
      end else if (fr_mag.size() == 0) begin
         exp_err.push_back(edge_n);
         m_hunt = 1'b1;
         return;
      end
      fr_mag.push_back(mag_sq(re, im));
      if (fr_mag.size() == N) begin
         best = FIRST;
         for (int i = FIRST + 1; i < N; i++)
            if (fr_mag[i] > fr_mag[best]) best = i;
         r.bin = best;
         r.mag = fr_mag[best];
         r.cyc = edge_n + 3;
         exp_rep.push_back(r);
         fr_mag.delete();
      end
   endtask

   // ---------------- monitor ----------------
   rep_t   mon_r;
   longint mon_e;

   always @(negedge clk) begin
      if (o_valid) begin
         if (exp_rep.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: bin %0d mag %0d at cycle %0d, none expected",
                     o_peak_bin, o_peak_mag, cyc);
         end else begin
            mon_r = exp_rep.pop_front();
            check("peak_bin", longint'(o_peak_bin), longint'(mon_r.bin));
            check("peak_mag", longint'(o_peak_mag), mon_r.mag);
            check("valid_cycle", cyc, mon_r.cyc);
         end
      end
      if (o_frame_err) begin
         if (exp_err.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame_err: pulse at cycle %0d, none expected", cyc);
         end else begin
            mon_e = exp_err.pop_front();
            check("frame_err_cycle", cyc, mon_e);
         end
      end
   end

   // ---------------- stimulus ----------------
   int f_re[N];
   int f_im[N];

   task automatic put(input bit ce, input int re, input int im, input bit sync);
      @(negedge clk);
      i_ce     = ce;
      i_sync   = sync;
      i_result = {re[IW-1:0], im[IW-1:0]};
      if (ce) model_accept(re, im, sync, cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) put(1'b0, int'($urandom_range(0, 65535)) - 32768, 7, 1'($urandom_range(0, 1)));
   endtask

   task automatic fill(input int re, input int im);
      for (int i = 0; i < N; i++) begin
         f_re[i] = re;
         f_im[i] = im;
      end
   endtask

   // gap_mode: 0 = i_ce every cycle, 1 = i_ce toggling, 2 = random gaps.
   task automatic send_frame(input int gap_mode, input int nbins);
      for (int i = 0; i < nbins; i++) begin
         if (gap_mode == 1 && i > 0) idle(1);
         if (gap_mode == 2) idle(int'($urandom_range(0, 3)));
         put(1'b1, f_re[i], f_im[i], i == 0);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst  = 1'b0;
      i_ce = 1'b0;
      m_hunt = 1'b1;
      fr_mag.delete();
      @(negedge clk);
      check({tag, "_bin"}, longint'(o_peak_bin), 0);
      check({tag, "_mag"}, longint'(o_peak_mag), 0);
      check({tag, "_valid"}, longint'(o_valid), 0);
      check({tag, "_frame_err"}, longint'(o_frame_err), 0);
      rst = 1'b1;
   endtask

   initial begin
      do_reset("reset");
      idle(3);

      // Single dominant bin, i_ce every cycle.
      fill(10, 10);
      f_re[5] = 300;
      f_im[5] = -400;
      send_frame(0, N);
      idle(8);
      check("dominant_bin", longint'(o_peak_bin), 5);
      check("dominant_mag", longint'(o_peak_mag), 250000);

      // Full-scale tie: lowest index wins, with and without i_ce gaps.
      for (int mode = 0; mode < 2; mode++) begin
         fill(0, 0);
         f_re[3] = -32768;
         f_re[9] = -32768;
         send_frame(mode, N);
         idle(8);
         check("tie_bin", longint'(o_peak_bin), 3);
         check("tie_mag", longint'(o_peak_mag), 1073741824);
      end

      // DC handling.
      fill(0, 0);
      f_re[0] = 1000;
      f_re[7] = 20;
      send_frame(0, N);
      idle(8);
`ifdef FFT_PEAK_SKIP_DC_EN
      check("dc_bin", longint'(o_peak_bin), 7);
      check("dc_mag", longint'(o_peak_mag), 400);
`else
      check("dc_bin", longint'(o_peak_bin), 0);
      check("dc_mag", longint'(o_peak_mag), 1000000);
`endif

      // Early sync at bin 6 aborts the frame; the next frame reports.
      fill(50, 0);
      f_re[2] = 9000;
      send_frame(0, 6);
      fill(1, 1);
      f_im[11] = -700;
      send_frame(0, N);
      idle(8);
      check("abort_bin", longint'(o_peak_bin), 11);

      // Missing sync after bin 15: one error, then ignored until a sync.
      fill(2, 2);
      f_re[4] = 77;
      send_frame(0, N);
      repeat (3) put(1'b1, 5000, 5000, 1'b0);
      idle(2);
      fill(3, -3);
      f_re[13] = -123;
      send_frame(0, N);
      idle(8);
      check("resync_bin", longint'(o_peak_bin), 13);

      // Reset at bin 8 drops the frame; the next frame reports.
      fill(4, 4);
      f_re[6] = 2000;
      send_frame(0, 8);
      do_reset("midreset");
      idle(6);
      fill(0, 9);
      f_im[10] = 31000;
      send_frame(0, N);
      idle(8);
      check("post_reset_bin", longint'(o_peak_bin), 10);

      // Back-to-back frames.
      fill(5, 5);
      f_re[2] = 100;
      f_im[2] = 100;
      send_frame(0, N);
      fill(5, 5);
      f_re[14] = -200;
      send_frame(0, N);
      idle(8);
      check("b2b_last_bin", longint'(o_peak_bin), 14);

      // Randomised frames: small ranges give ties, full range stresses width.
      for (int f = 0; f < 14; f++) begin
         for (int i = 0; i < N; i++) begin
            if (f % 2 == 0) begin
               f_re[i] = int'($urandom_range(0, 4)) - 2;
               f_im[i] = int'($urandom_range(0, 4)) - 2;
            end else begin
               f_re[i] = int'($urandom_range(0, 65535)) - 32768;
               f_im[i] = int'($urandom_range(0, 65535)) - 32768;
            end
         end
         if (f % 4 == 3) send_frame(2, int'($urandom_range(1, N - 1)));
         send_frame(f % 3 == 0 ? 0 : 2, N);
      end
      idle(10);

      check("pending_reports", longint'(exp_rep.size()), 0);
      check("pending_frame_errs", longint'(exp_err.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
